// File: rtl/vec_lane_sequencer.sv
// Vector-to-scalar lane sequencer: captures a 16-lane operand and streams
// its lanes one element per handshake, lane 0 first, through a 16:1 mux.

module mux16_1 #(
  parameter int N = 4
) (
  input  logic [16*N-1:0] i_data,
  input  logic [3:0]      i_sel,
  output logic [N-1:0]    o_data
);
  assign o_data = i_data[i_sel*N +: N];
endmodule

module vec_lane_sequencer #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [16*N-1:0] vec_in,
  input  logic [4:0]      count,
  input  logic            load,
  output logic            in_ready,
  input  logic            abort,
  output logic [N-1:0]    elem_out,
  output logic            elem_valid,
  input  logic            elem_ready,
  output logic [3:0]      sel,
  output logic            last,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [16*N-1:0]   r_lanes;
  logic [3:0]        r_idx;
  logic [3:0]        w_idx_nx;
  logic [4:0]        r_len;
  logic [4:0]        w_len_in;
  logic [4:0]        w_len_m1;
  logic              w_capture;
  logic              w_at_last;

  // A count of 0 or anything above 16 selects the full vector.
  assign w_len_in  = ((count == 5'd0) || (count > 5'd16)) ? 5'd16 : count;
  assign w_len_m1  = r_len - 5'd1;
  assign w_at_last = (r_idx == w_len_m1[3:0]);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_capture  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (load) begin
          w_capture  = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (elem_ready) begin
          if (w_at_last) w_state_nx = S_DONE;
          else           w_idx_nx   = r_idx + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = '0;
      end
    endcase
    // Flush wins over capture and over the handshake.
    if (abort) begin
      w_state_nx = S_IDLE;
      w_idx_nx   = '0;
      w_capture  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_lanes <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      if (w_capture) begin
        r_lanes <= vec_in;
        r_len   <= w_len_in;
      end
    end
  end

  mux16_1 #(.N(N)) u_mux (
    .i_data (r_lanes),
    .i_sel  (r_idx),
    .o_data (elem_out)
  );

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign elem_valid = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign sel        = r_idx;
  assign last       = (r_state == S_RUN) && w_at_last;

endmodule
